// File: rtl/dm_store_buffer_if.sv
// Store, load-lookup and DM-drain signals of the posted-store buffer.
// The master modport is the store/load pipeline side, and the slave modport is the buffer.
interface dm_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_data;

  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_fwd_be;
  logic [DATA_W-1:0] ld_fwd_data;
  logic              ld_conflict;

  logic              dm_hold;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [DATA_W-1:0] dm_din;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_be, st_data, ld_addr, dm_hold,
    input  st_ready, ld_fwd_be, ld_fwd_data, ld_conflict,
           dm_wr, dm_addr, dm_be, dm_din, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_be, st_data, ld_addr, dm_hold,
    output st_ready, ld_fwd_be, ld_fwd_data, ld_conflict,
           dm_wr, dm_addr, dm_be, dm_din, empty, count
  );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-store FIFO between store alignment and data memory, with a word-address load lookup.
// When STBUF_FWD_EN is defined, the buffer forwards the youngest pending bytes to loads. Otherwise it only flags conflicts.
module dm_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_store_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [3:0]        r_be   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_conflict;
  logic [3:0]        w_fwd_be;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_unused;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count != CNT_W'(DEPTH));
  assign w_push  = bus.st_valid && w_ready;
  assign w_pop   = !w_empty && !bus.dm_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_be[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // A push and a pop can never target the same slot. The slots collide only when the buffer is empty or full.
      if (w_push) begin
        r_addr[r_tail]  <= bus.st_addr;
        r_be[r_tail]    <= bus.st_be;
        r_data[r_tail]  <= bus.st_data;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The scan runs oldest to youngest, so a younger matching entry overwrites the lanes of an older one.
  always_comb begin
    w_conflict = 1'b0;
    w_fwd_be   = '0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[r_head + PTR_W'(k)] &&
          (r_addr[r_head + PTR_W'(k)][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
        w_conflict = 1'b1;
`ifdef STBUF_FWD_EN
        for (int j = 0; j < 4; j++) begin
          if (r_be[r_head + PTR_W'(k)][j]) begin
            w_fwd_be[j]          = 1'b1;
            w_fwd_data[8*j +: 8] = r_data[r_head + PTR_W'(k)][8*j +: 8];
          end
        end
`endif
      end
    end
  end

  assign w_unused = &{1'b0, bus.ld_addr[1:0]};

  assign bus.st_ready    = w_ready;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.dm_wr       = w_pop;
  assign bus.dm_addr     = w_empty ? '0 : r_addr[r_head];
  assign bus.dm_be       = w_empty ? '0 : r_be[r_head];
  assign bus.dm_din      = w_empty ? '0 : r_data[r_head];
  assign bus.ld_conflict = w_conflict;
  assign bus.ld_fwd_be   = w_fwd_be;
  assign bus.ld_fwd_data = w_fwd_data;
endmodule
